ram_sp_req_sequencer: RTL
=========================

Name: ram_sp_req_sequencer

Overview:
- Request sequencer sitting directly upstream of the single-port sync-read/sync-write RAM (ram_sp_sr_sw) inside ram_controller.
- Converts a valid/ready request stream (read/write, address, write data) into correctly timed cs/we/oe/data strobes.
- Returns one response per request on a valid/ready response channel.
- Owns the RAM data-bus turnaround: drive enable is asserted only during write strobes.

Parameters:
DATA_WIDTH  16  RAM word width in bits
ADDR_WIDTH  8   RAM address width in bits
RAM_DEPTH   256 number of valid words; must satisfy RAM_DEPTH <= 2**ADDR_WIDTH

Ports:
clk            input   1           single clock; all logic on posedge
rst_n          input   1           asynchronous active-low reset
req_valid      input   1           request present
req_ready      output  1           sequencer can accept a request
req_we         input   1           1 = write, 0 = read
req_addr       input   ADDR_WIDTH  word address
req_wdata      input   DATA_WIDTH  write data
rsp_valid      output  1           response present
rsp_ready      input   1           consumer accepts response
rsp_rdata      output  DATA_WIDTH  read data; 0 for writes
rsp_err        output  1           request rejected (only with optional feature; else tied 0)
ram_address    output  ADDR_WIDTH  to RAM address
ram_cs         output  1           RAM chip select
ram_we         output  1           RAM write enable
ram_oe         output  1           RAM output enable
ram_data_out   output  DATA_WIDTH  write data to RAM bus
ram_data_drive output  1           tristate enable for ram_data_out; parent ties the bus
ram_data_in    input   DATA_WIDTH  read data from RAM bus
txn_count      output  16          completed responses, saturating

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All outputs = 0, including address/data registers and txn_count.
  - An in-flight transaction is dropped with no response.
  - On deassertion, req_ready rises at the first clock edge after rst_n=1.
- States: IDLE, WR, RD_ISSUE, RD_CAPTURE, RESP.
- IDLE:
  - req_ready=1. Handshake = req_valid & req_ready.
  - On handshake, register req_addr, req_wdata and req_we.
  - Next state is WR if req_we=1, else RD_ISSUE. No handshake: stay in IDLE.
- req_ready is 0 in every state other than IDLE. One transaction outstanding maximum.
- WR (1 cycle):
  - ram_cs=1, ram_we=1, ram_oe=0, ram_data_drive=1.
  - ram_address and ram_data_out come from the registered values. Next state: RESP.
- RD_ISSUE (1 cycle):
  - ram_cs=1, ram_we=0, ram_oe=1, ram_data_drive=0. Next state: RD_CAPTURE.
- RD_CAPTURE (1 cycle):
  - ram_cs=1, ram_oe=1.
  - At the end of the cycle, capture ram_data_in into the rsp_rdata register. This matches the RAM's one-cycle sync-read latency. Next state: RESP.
- RESP:
  - rsp_valid=1; rsp_rdata is held stable (0 for writes).
  - Stay until rsp_ready=1, then return to IDLE and increment txn_count.
  - txn_count saturates at 16'hFFFF.
- Outside WR/RD_ISSUE/RD_CAPTURE: ram_cs=ram_we=ram_oe=ram_data_drive=0. ram_address holds its last value.
- ram_we and ram_oe are never both 1 in the same cycle.
- ram_data_drive is 1 only when ram_we=1.
- Latency, handshake cycle to first rsp_valid cycle (back-to-back throughput assumes rsp_ready held 1):
  - Write: 2 cycles; back-to-back throughput is 1 request per 3 cycles.
  - Read: 3 cycles; back-to-back throughput is 1 request per 4 cycles.
- Inputs req_* are don't-care when req_valid=0. Request fields are sampled only at the handshake.
- rsp_ready asserted while rsp_valid=0 has no effect.

Optional Feature:
- Macro: RAM_SP_REQ_SEQUENCER_ADDR_CHECK_EN
- Defined:
  - A request with req_addr >= RAM_DEPTH skips WR/RD states and goes IDLE -> RESP directly.
  - RAM strobes stay 0. RESP presents rsp_err=1 and rsp_rdata=0.
  - rsp_err=0 for all in-range requests. txn_count still increments.
- Undefined:
  - No address comparison; all addresses are issued to the RAM.
  - rsp_err is constant 0.

Test Plan:
- Reset mid-read: assert rst_n=0 during RD_CAPTURE -> all outputs 0 immediately; no rsp_valid after release; req_ready=1 one edge after release.
- Write/read-back: write addr 8'h3C data 16'hA5A5, then read 8'h3C with rsp_ready=1 -> write strobe lasts exactly 1 cycle with ram_data_drive=1; read rsp_rdata=16'hA5A5 three cycles after the read handshake; txn_count=2.
- Response backpressure: read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable for all 5 cycles; req_ready=0 throughout; no RAM strobes after RD_CAPTURE.
- Strobe exclusivity: 100 random reads/writes -> ram_we&ram_oe never 1; ram_data_drive never 1 without ram_we; every response matches a scoreboard RAM model.
- txn_count saturation: preload via 65535 back-to-back transactions plus 2 more -> txn_count=16'hFFFF, no wrap.
- Feature on, RAM_DEPTH=200: read addr 8'd200 -> no ram_cs; rsp_err=1, rsp_rdata=0, response 1 cycle after handshake. Read addr 8'd199 -> rsp_err=0, normal 3-cycle latency.

Source files
------------

// File: rtl/ram_sp_req_sequencer.sv
// Request sequencer driving the strobes of a single-port sync-read/sync-write RAM.
// Optional out-of-range rejection when RAM_SP_REQ_SEQUENCER_ADDR_CHECK_EN is defined.
`timescale 1ns/1ps

module ram_sp_req_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_data_drive,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [15:0]           txn_count
);

`ifdef RAM_SP_REQ_SEQUENCER_ADDR_CHECK_EN
  localparam bit ADDR_CHECK_EN = 1'b1;
`else
  localparam bit ADDR_CHECK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_CAPTURE,
    ST_RESP
  } state_e;

  state_e                state_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic [ADDR_WIDTH-1:0] ram_address_q;
  logic                  ram_cs_q;
  logic                  ram_we_q;
  logic                  ram_oe_q;
  logic [DATA_WIDTH-1:0] ram_data_out_q;
  logic                  ram_data_drive_q;
  logic [15:0]           txn_count_q;
  logic [15:0]           txn_count_d;
  logic                  addr_in_range;
  logic                  req_hs;

  assign req_hs        = req_valid & req_ready_q;
  assign addr_in_range = 32'(req_addr) < 32'(RAM_DEPTH);
  assign txn_count_d   = (txn_count_q == 16'hFFFF) ? txn_count_q : txn_count_q + 16'd1;

  // Every output is a register loaded on the transition into the state that
  // owns it, so strobes change cleanly on the clock edge with no decode glitch.
  // NOTE: state and outputs use non-blocking assignments so every register in
  // this block samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      req_ready_q      <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= '0;
      rsp_err_q        <= 1'b0;
      ram_address_q    <= '0;
      ram_cs_q         <= 1'b0;
      ram_we_q         <= 1'b0;
      ram_oe_q         <= 1'b0;
      ram_data_out_q   <= '0;
      ram_data_drive_q <= 1'b0;
      txn_count_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_hs) begin
            req_ready_q <= 1'b0;
            rsp_rdata_q <= '0;
            if (ADDR_CHECK_EN && !addr_in_range) begin
              // Rejected request never touches the RAM.
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              rsp_err_q     <= 1'b0;
              ram_address_q <= req_addr;
              ram_cs_q      <= 1'b1;
              if (req_we) begin
                ram_we_q         <= 1'b1;
                ram_data_drive_q <= 1'b1;
                ram_data_out_q   <= req_wdata;
                state_q          <= ST_WR;
              end else begin
                ram_oe_q <= 1'b1;
                state_q  <= ST_RD_ISSUE;
              end
            end
          end
        end

        ST_WR: begin
          ram_cs_q         <= 1'b0;
          ram_we_q         <= 1'b0;
          ram_data_drive_q <= 1'b0;
          rsp_valid_q      <= 1'b1;
          state_q          <= ST_RESP;
        end

        ST_RD_ISSUE: begin
          state_q <= ST_RD_CAPTURE;
        end

        ST_RD_CAPTURE: begin
          // RAM output register became valid one edge after the read strobe.
          rsp_rdata_q <= ram_data_in;
          ram_cs_q    <= 1'b0;
          ram_oe_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            txn_count_q <= txn_count_d;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          ram_cs_q         <= 1'b0;
          ram_we_q         <= 1'b0;
          ram_oe_q         <= 1'b0;
          ram_data_drive_q <= 1'b0;
          rsp_valid_q      <= 1'b0;
          req_ready_q      <= 1'b0;
          state_q          <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign ram_address    = ram_address_q;
  assign ram_cs         = ram_cs_q;
  assign ram_we         = ram_we_q;
  assign ram_oe         = ram_oe_q;
  assign ram_data_out   = ram_data_out_q;
  assign ram_data_drive = ram_data_drive_q;
  assign txn_count      = txn_count_q;

endmodule
